// File: rtl/insn_fetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Word tags are byte addresses with the two alignment bits removed.
package insn_fetch_responder_pkg;

  localparam int          ADDR_W     = 32;
  localparam int          WADDR_W    = ADDR_W - 2;
  localparam logic        RST_ACTIVE = 1'b0;
  localparam logic [31:0] INSN_NOP   = 32'h0;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/insn_fetch_responder_fetch_line_buf.sv
// One-entry last-word buffer: tag/data/valid with a combinational hit compare.
// A write takes priority over an invalidate in the same cycle.
module fetch_line_buf
  import insn_fetch_responder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [WADDR_W-1:0] lookup_tag,
  output logic               hit,
  output logic [31:0]        data,
  input  logic               wr_en,
  input  logic [WADDR_W-1:0] wr_tag,
  input  logic [31:0]        wr_data,
  input  logic               inv
);

  logic               valid;
  logic [WADDR_W-1:0] tag;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= INSN_NOP;
    end else if (wr_en) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end else if (inv) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (lookup_tag == tag);

endmodule

// File: rtl/insn_fetch_responder.sv
// IF-side fetch responder: hits/misaligned answer 1 cycle after accept, misses 1 cycle after mem_ack.
// Backpressure via registered busy, high from the cycle after a miss accept until the response/drain ends.
module insn_fetch_responder
  import insn_fetch_responder_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] insn,
  output logic        insn_valid,
  output logic        insn_err,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int             CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  fetch_state_t       state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [WADDR_W-1:0] pend_tag;
  logic               buf_hit;
  logic [31:0]        buf_data;
  logic               buf_wr;
  logic               buf_inv;
  logic               accept;
  logic               misaligned;
  logic               timed_out;
  logic               in_flight;

  assign in_flight  = (state == FETCH_WAIT) || (state == FETCH_DRAIN);
  assign accept     = (state == FETCH_IDLE) && if_req && !busy && !if_flush;
  assign misaligned = |if_addr[1:0];
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  // Fires in the last allowed cycle, so mem_req is held for exactly TIMEOUT cycles.
  assign timed_out  = (cnt_inc == CNT_MAX);
  assign buf_wr     = in_flight && mem_ack;
  assign buf_inv    = (state == FETCH_WAIT) && !mem_ack && timed_out;

  // pend_tag is the registered bus address; it only changes on accept, so it is stable under mem_req.
  assign mem_addr = {pend_tag, 2'b00};

  fetch_line_buf u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (if_addr[31:2]),
    .hit        (buf_hit),
    .data       (buf_data),
    .wr_en      (buf_wr),
    .wr_tag     (pend_tag),
    .wr_data    (mem_rdata),
    .inv        (buf_inv)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state      <= FETCH_IDLE;
      cnt        <= '0;
      pend_tag   <= '0;
      insn       <= INSN_NOP;
      insn_valid <= 1'b0;
      insn_err   <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
    end else begin
      insn_valid <= 1'b0;
      insn_err   <= 1'b0;
      case (state)
        FETCH_IDLE: begin
          if (accept) begin
            if (misaligned) begin
              insn_valid <= 1'b1;
              insn_err   <= 1'b1;
              insn       <= INSN_NOP;
            end else if (buf_hit) begin
              insn_valid <= 1'b1;
              insn       <= buf_data;
            end else begin
              pend_tag <= if_addr[31:2];
              mem_req  <= 1'b1;
              busy     <= 1'b1;
              cnt      <= '0;
              state    <= FETCH_WAIT;
            end
          end
        end
        FETCH_WAIT: begin
          cnt <= cnt_inc;
          if (mem_ack) begin
            state   <= FETCH_IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            // A flush arriving with the ack still fills the buffer but suppresses the response.
            if (!if_flush) begin
              insn_valid <= 1'b1;
              insn       <= mem_rdata;
            end
          end else if (timed_out) begin
            state      <= FETCH_IDLE;
            mem_req    <= 1'b0;
            busy       <= 1'b0;
            insn_valid <= 1'b1;
            insn_err   <= 1'b1;
            insn       <= INSN_NOP;
          end else if (if_flush) begin
            state <= FETCH_DRAIN;
          end
        end
        FETCH_DRAIN: begin
          cnt <= cnt_inc;
          if (mem_ack || timed_out) begin
            state   <= FETCH_IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= FETCH_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_insn_fetch_responder.sv
// Directed bench for insn_fetch_responder with TIMEOUT=4; inputs driven and outputs sampled 1ns after the rising edge.
module tb_insn_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] insn;
  logic        insn_valid;
  logic        insn_err;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  insn_fetch_responder #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .insn       (insn),
    .insn_valid (insn_valid),
    .insn_err   (insn_err),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;
    #3;
    check("rst_insn",       insn,       32'h0);
    check("rst_insn_valid", insn_valid, 32'h0);
    check("rst_insn_err",   insn_err,   32'h0);
    check("rst_busy",       busy,       32'h0);
    check("rst_mem_req",    mem_req,    32'h0);
    check("rst_mem_addr",   mem_addr,   32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Miss on 0x100, ack in the second WAIT cycle, then a buffer hit.
    fetch(32'h100);
    tick();
    check("miss_mem_req",  mem_req,  32'h1);
    check("miss_mem_addr", mem_addr, 32'h100);
    check("miss_busy",     busy,     32'h1);
    check("miss_no_valid", insn_valid, 32'h0);
    if_req = 1'b0;
    tick();
    check("miss_req_held",  mem_req,  32'h1);
    check("miss_addr_held", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'h3C011234;
    tick();
    mem_ack = 1'b0;
    check("miss_valid",   insn_valid, 32'h1);
    check("miss_insn",    insn,       32'h3C011234);
    check("miss_err",     insn_err,   32'h0);
    check("miss_busy_lo", busy,       32'h0);
    check("miss_req_lo",  mem_req,    32'h0);
    fetch(32'h100);
    tick();
    if_req = 1'b0;
    check("hit_valid",  insn_valid, 32'h1);
    check("hit_insn",   insn,       32'h3C011234);
    check("hit_no_req", mem_req,    32'h0);
    tick();
    check("pulse_end", insn_valid, 32'h0);

    // Misaligned fetch: error response, buffer untouched.
    fetch(32'h102);
    tick();
    if_req = 1'b0;
    check("mis_valid",  insn_valid, 32'h1);
    check("mis_err",    insn_err,   32'h1);
    check("mis_insn",   insn,       32'h0);
    check("mis_no_req", mem_req,    32'h0);
    fetch(32'h100);
    tick();
    if_req = 1'b0;
    check("mis_buf_kept", insn, 32'h3C011234);
    check("mis_buf_err",  insn_err, 32'h0);

    // Flush while waiting: drain, no response, buffer still filled.
    fetch(32'h200);
    tick();
    if_req = 1'b0;
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    check("drain_busy", busy,    32'h1);
    check("drain_req",  mem_req, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h8C220004;
    tick();
    mem_ack = 1'b0;
    check("drain_no_valid", insn_valid, 32'h0);
    check("drain_busy_lo",  busy,       32'h0);
    check("drain_req_lo",   mem_req,    32'h0);
    fetch(32'h200);
    tick();
    if_req = 1'b0;
    check("drain_hit_valid", insn_valid, 32'h1);
    check("drain_hit_insn",  insn,       32'h8C220004);
    check("drain_hit_noreq", mem_req,    32'h0);

    // Ack and flush in the same WAIT cycle: ack wins, response suppressed.
    fetch(32'h240);
    tick();
    if_req = 1'b0;
    if_flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h11112222;
    tick();
    if_flush = 1'b0; mem_ack = 1'b0;
    check("ackfl_no_valid", insn_valid, 32'h0);
    check("ackfl_busy",     busy,       32'h0);
    fetch(32'h240);
    tick();
    if_req = 1'b0;
    check("ackfl_hit", insn, 32'h11112222);

    // Request with flush in IDLE is ignored; stray ack in IDLE is ignored.
    fetch(32'h600);
    if_flush = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    if_req = 1'b0; if_flush = 1'b0; mem_ack = 1'b0;
    check("flreq_no_req",   mem_req,    32'h0);
    check("flreq_no_valid", insn_valid, 32'h0);
    check("flreq_no_busy",  busy,       32'h0);

    // Same-cycle bus fill of 0x300, then four back-to-back hits.
    fetch(32'h300);
    tick();
    if_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hAAAA0300;
    tick();
    mem_ack = 1'b0;
    check("fast_valid", insn_valid, 32'h1);
    check("fast_insn",  insn,       32'hAAAA0300);
    fetch(32'h300);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("b2b_valid%0d", i), insn_valid, 32'h1);
      check($sformatf("b2b_insn%0d", i),  insn,       32'hAAAA0300);
      check($sformatf("b2b_busy%0d", i),  busy,       32'h0);
    end
    if_req = 1'b0;
    tick();
    check("b2b_end", insn_valid, 32'h0);

    // Timeout: mem_req held for exactly 4 WAIT cycles, then error and buffer invalidated.
    fetch(32'h400);
    tick();
    if_req = 1'b0;
    check("to_req0", mem_req, 32'h1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("to_req%0d", i), mem_req, 32'h1);
    end
    tick();
    check("to_req_lo", mem_req,    32'h0);
    check("to_valid",  insn_valid, 32'h1);
    check("to_err",    insn_err,   32'h1);
    check("to_insn",   insn,       32'h0);
    check("to_busy",   busy,       32'h0);
    fetch(32'h300);
    tick();
    if_req = 1'b0;
    check("to_buf_inv_req",   mem_req,    32'h1);
    check("to_buf_inv_valid", insn_valid, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_ack = 1'b0;

    // Reset mid-fetch with 0x100 buffered: outputs clear at once, buffer cleared.
    fetch(32'h100);
    tick();
    if_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h3C011234;
    tick();
    mem_ack = 1'b0;
    check("pre_rst_insn", insn, 32'h3C011234);
    fetch(32'h500);
    tick();
    if_req = 1'b0;
    check("pre_rst_req", mem_req, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_req",   mem_req,  32'h0);
    check("arst_busy",  busy,     32'h0);
    check("arst_addr",  mem_addr, 32'h0);
    check("arst_insn",  insn,     32'h0);
    tick();
    rst = 1'b1;
    fetch(32'h100);
    tick();
    if_req = 1'b0;
    check("post_rst_req",   mem_req,    32'h1);
    check("post_rst_addr",  mem_addr,   32'h100);
    check("post_rst_valid", insn_valid, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h3C011234;
    tick();
    mem_ack = 1'b0;
    check("post_rst_fill", insn, 32'h3C011234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
